// File: rtl/dds_phase_sweep_pkg.sv
// Shared widths and sweep state encoding for the DDS phase sweep block.
package dds_pkg;

    localparam int ACC_BITS   = 32;
    localparam int FCW_BITS   = 32;
    localparam int STEP_BITS  = 24;
    localparam int DWELL_BITS = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/dds_phase_sweep_if.sv
// Configuration handshake bundle: one valid/ready transfer latches every field at once.
interface dds_cfg_if #(
    parameter int FCW_BITS   = dds_pkg::FCW_BITS,
    parameter int STEP_BITS  = dds_pkg::STEP_BITS,
    parameter int DWELL_BITS = dds_pkg::DWELL_BITS
);

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [FCW_BITS-1:0]   cfg_fcw_start;
    logic [FCW_BITS-1:0]   cfg_fcw_stop;
    logic [STEP_BITS-1:0]  cfg_fcw_step;
    logic [DWELL_BITS-1:0] cfg_dwell;
    logic                  cfg_repeat;

    modport master (
        output cfg_valid, cfg_fcw_start, cfg_fcw_stop, cfg_fcw_step, cfg_dwell, cfg_repeat,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_fcw_start, cfg_fcw_stop, cfg_fcw_step, cfg_dwell, cfg_repeat,
        output cfg_ready
    );

endinterface

// File: rtl/dds_phase_acc.sv
// Free-wrapping phase accumulator; a new fcw is first reflected in phase one edge later.
module dds_phase_acc import dds_pkg::*; #(
    parameter int WIDTH = ACC_BITS
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] fcw,
    output logic [WIDTH-1:0] phase,
    output logic             valid
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            phase <= '0;
            valid <= 1'b0;
        end else begin
            phase <= phase + fcw;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/dds_phase_sweep.sv
// DDS phase source: static tone or stepped linear FCW sweep with clamp at the stop FCW.
module dds_phase_sweep import dds_pkg::*; #(
    parameter int ACC_BITS   = dds_pkg::ACC_BITS,
    parameter int FCW_BITS   = dds_pkg::FCW_BITS,
    parameter int STEP_BITS  = dds_pkg::STEP_BITS,
    parameter int DWELL_BITS = dds_pkg::DWELL_BITS
) (
    input  logic                CLK,
    input  logic                RSTN,
    dds_cfg_if.slave            cfg,
    input  logic                start,
    input  logic                abort,
    output logic [ACC_BITS-1:0] phase_o,
    output logic                phase_valid,
    output logic [FCW_BITS-1:0] fcw_o,
    output logic                busy,
    output logic                sweep_done
);

    sweep_state_t          state, state_d;
    logic [FCW_BITS-1:0]   start_q, stop_q, fcw_q, fcw_d;
    logic [STEP_BITS-1:0]  step_q;
    logic [DWELL_BITS-1:0] dwell_q, dwell_cnt, dwell_d;
    logic                  repeat_q, done_q, done_d;

    logic                  cfg_xfer;
    logic [FCW_BITS-1:0]   eff_start, eff_stop;
    logic [STEP_BITS-1:0]  eff_step;
    logic [DWELL_BITS-1:0] eff_dwell;
    logic [FCW_BITS:0]     sum;
    logic                  clamp;

    assign cfg.cfg_ready = (state == IDLE);
    assign cfg_xfer      = cfg.cfg_valid && cfg.cfg_ready;

    // A start in the same cycle as a config transfer must see the incoming fields.
    assign eff_start = cfg_xfer ? cfg.cfg_fcw_start : start_q;
    assign eff_stop  = cfg_xfer ? cfg.cfg_fcw_stop  : stop_q;
    assign eff_step  = cfg_xfer ? cfg.cfg_fcw_step  : step_q;
    assign eff_dwell = cfg_xfer ? cfg.cfg_dwell     : dwell_q;

    assign sum   = {1'b0, fcw_q} + {1'b0, FCW_BITS'(step_q)};
    assign clamp = sum[FCW_BITS] || (sum[FCW_BITS-1:0] >= stop_q);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        fcw_d   = fcw_q;
        dwell_d = dwell_cnt;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    fcw_d = eff_start;
                    if (eff_step == '0 || eff_start >= eff_stop) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SWEEP;
                        dwell_d = eff_dwell;
                    end
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dwell_cnt != '0) begin
                    dwell_d = dwell_cnt - DWELL_BITS'(1);
                end else begin
                    dwell_d = dwell_q;
                    if (fcw_q == stop_q) begin
                        if (repeat_q) begin
                            fcw_d = start_q;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (clamp) begin
                        fcw_d = stop_q;
                    end else begin
                        fcw_d = sum[FCW_BITS-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= IDLE;
            fcw_q     <= '0;
            dwell_cnt <= '0;
            done_q    <= 1'b0;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            dwell_q   <= '0;
            repeat_q  <= 1'b0;
        end else begin
            state     <= state_d;
            fcw_q     <= fcw_d;
            dwell_cnt <= dwell_d;
            done_q    <= done_d;
            if (cfg_xfer) begin
                start_q  <= cfg.cfg_fcw_start;
                stop_q   <= cfg.cfg_fcw_stop;
                step_q   <= cfg.cfg_fcw_step;
                dwell_q  <= cfg.cfg_dwell;
                repeat_q <= cfg.cfg_repeat;
            end
        end
    end

    assign fcw_o      = fcw_q;
    assign busy       = (state == SWEEP);
    assign sweep_done = done_q;

    dds_phase_acc #(.WIDTH(ACC_BITS)) u_acc (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .fcw   (fcw_q),
        .phase (phase_o),
        .valid (phase_valid)
    );

endmodule
